// File: rtl/pong_pkg.sv
// Shared constants and state type for the pong ball datapath.
// Consumed by ball_motion_engine and ball_pixel_pipe.
package pong_pkg;

    localparam int BALL_SIZE = 32;
    localparam int SCR_W     = 640;
    localparam int SCR_H     = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        MISS = 2'd2
    } ball_state_t;

endpackage

// File: rtl/ball_pixel_pipe.sv
// Ball bitmap lookup: offset compute, ROM row address, registered ball_on.
// The ROM returns its row combinationally for the address driven here.
module ball_pixel_pipe
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [0:31] rom_data,
    output logic [4:0]  rom_addr,
    output logic        ball_on
);

    logic [10:0] w_ox;
    logic [10:0] w_oy;
    logic        w_in_box;
    logic        r_ball_on;

    // Pixels left of or above the ball wrap to large offsets and fail the box test
    assign w_ox = {1'b0, pixel_x} - {1'b0, ball_x};
    assign w_oy = {1'b0, pixel_y} - {1'b0, ball_y};

    assign w_in_box = video_on
                    && (w_ox < 11'(BALL_SIZE))
                    && (w_oy < 11'(BALL_SIZE));

    assign rom_addr = w_in_box ? w_oy[4:0] : 5'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ball_on <= 1'b0;
        else
            r_ball_on <= w_in_box & rom_data[w_ox[4:0]];
    end

    assign ball_on = r_ball_on;

endmodule

// File: rtl/ball_motion_engine.sv
// Pong ball motion FSM (IDLE/PLAY/MISS), wall and paddle bounces, miss pulses.
// Optional BALL_SPEEDUP_EN: each paddle hit raises speed by one up to MAX_V.
module ball_motion_engine
    import pong_pkg::*;
#(
    parameter int H_MAX       = SCR_W,
    parameter int V_MAX       = SCR_H,
    parameter int PAD_L_X     = 32,
    parameter int PAD_R_X     = 600,
    parameter int PAD_W       = 8,
    parameter int PAD_H       = 72,
    parameter int BALL_V      = 2,
    parameter int MAX_V       = 6,
    parameter int MISS_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic        serve_dir,
    input  logic [9:0]  pad_l_y,
    input  logic [9:0]  pad_r_y,
    output logic [4:0]  rom_addr,
    input  logic [0:31] rom_data,
    output logic        ball_on,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic        hit,
    output logic        miss_left,
    output logic        miss_right
);

`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    localparam logic [10:0] L_BS   = 11'(BALL_SIZE);
    localparam logic [10:0] L_HM   = 11'(H_MAX);
    localparam logic [10:0] L_VM   = 11'(V_MAX);
    localparam logic [10:0] L_LF   = 11'(PAD_L_X + PAD_W);
    localparam logic [10:0] L_RF   = 11'(PAD_R_X);
    localparam logic [10:0] L_PH   = 11'(PAD_H);
    localparam logic [9:0]  L_CX   = 10'((H_MAX - BALL_SIZE) / 2);
    localparam logic [9:0]  L_CY   = 10'((V_MAX - BALL_SIZE) / 2);
    localparam logic [2:0]  L_V0   = 3'(BALL_V);
    localparam logic [2:0]  L_VMAX = 3'(MAX_V);
    localparam logic [7:0]  L_MF   = 8'(MISS_FRAMES - 1);

    ball_state_t r_state, w_state;
    logic [9:0]  r_x, r_y, w_x, w_y;
    logic        r_dx, r_dy, w_dx, w_dy;
    logic [2:0]  r_speed, w_speed, w_speed_hit;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_hit, r_ml, r_mr, w_hit, w_ml, w_mr;

    logic [10:0] w_x11, w_y11, w_sp, w_pl, w_pr;
    logic        w_l_ovl, w_r_ovl;
    logic        w_lhit, w_rhit, w_lmiss, w_rmiss;

    assign w_x11 = {1'b0, r_x};
    assign w_y11 = {1'b0, r_y};
    assign w_sp  = {8'd0, r_speed};
    assign w_pl  = {1'b0, pad_l_y};
    assign w_pr  = {1'b0, pad_r_y};

    assign w_l_ovl = (w_y11 + L_BS > w_pl) && (w_y11 < w_pl + L_PH);
    assign w_r_ovl = (w_y11 + L_BS > w_pr) && (w_y11 < w_pr + L_PH);

    // dx: 1 = right, dy: 1 = down
    assign w_lhit  = !r_dx && (w_x11 >= L_LF)
                   && (w_x11 < L_LF + w_sp) && w_l_ovl;
    assign w_rhit  = r_dx && (w_x11 + L_BS <= L_RF)
                   && (w_x11 + L_BS + w_sp > L_RF) && w_r_ovl;
    assign w_lmiss = !r_dx && (w_x11 < w_sp);
    assign w_rmiss = r_dx && (w_x11 + L_BS + w_sp > L_HM);

    assign w_speed_hit = (SPEEDUP && (r_speed < L_VMAX))
                       ? r_speed + 3'd1 : r_speed;

    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_dx    = r_dx;
        w_dy    = r_dy;
        w_speed = r_speed;
        w_cnt   = r_cnt;
        w_hit   = 1'b0;
        w_ml    = 1'b0;
        w_mr    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (serve) begin
                    w_state = PLAY;
                    w_dx    = serve_dir;
                    w_dy    = 1'b1;
                    w_speed = L_V0;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (!r_dy) begin
                        if (w_y11 < w_sp) begin
                            w_y  = '0;
                            w_dy = 1'b1;
                        end else begin
                            w_y = 10'(w_y11 - w_sp);
                        end
                    end else if (w_y11 + L_BS + w_sp > L_VM) begin
                        w_y  = 10'(L_VM - L_BS);
                        w_dy = 1'b0;
                    end else begin
                        w_y = 10'(w_y11 + w_sp);
                    end
                    if (w_lhit) begin
                        w_x     = 10'(L_LF);
                        w_dx    = 1'b1;
                        w_hit   = 1'b1;
                        w_speed = w_speed_hit;
                    end else if (w_rhit) begin
                        w_x     = 10'(L_RF - L_BS);
                        w_dx    = 1'b0;
                        w_hit   = 1'b1;
                        w_speed = w_speed_hit;
                    end else if (w_lmiss) begin
                        w_ml    = 1'b1;
                        w_state = MISS;
                    end else if (w_rmiss) begin
                        w_mr    = 1'b1;
                        w_state = MISS;
                    end else if (r_dx) begin
                        w_x = 10'(w_x11 + w_sp);
                    end else begin
                        w_x = 10'(w_x11 - w_sp);
                    end
                end
            end
            MISS: begin
                if (frame_tick) begin
                    if (r_cnt == L_MF) begin
                        w_state = IDLE;
                        w_x     = L_CX;
                        w_y     = L_CY;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= L_CX;
            r_y     <= L_CY;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
            r_speed <= L_V0;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_ml    <= 1'b0;
            r_mr    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_speed <= w_speed;
            r_cnt   <= w_cnt;
            r_hit   <= w_hit;
            r_ml    <= w_ml;
            r_mr    <= w_mr;
        end
    end

    assign ball_x     = r_x;
    assign ball_y     = r_y;
    assign hit        = r_hit;
    assign miss_left  = r_ml;
    assign miss_right = r_mr;

    ball_pixel_pipe u_pix (
        .clk      (clk),
        .reset    (reset),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .video_on (video_on),
        .ball_x   (r_x),
        .ball_y   (r_y),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .ball_on  (ball_on)
    );

endmodule

// File: doc/ball_motion_engine.md
# ball_motion_engine

Drives the ball sprite for the pong display: holds ball position and direction, advances it once per frame, bounces off walls and paddles, and reports misses. It also reads the ball bitmap ROM, driving the 5-bit row address and consuming the returned 32-bit row. From those rows it produces a registered per-pixel `ball_on` for the VGA colour mux. It sits between the VGA sync counter and the pixel mux, alongside the paddle and score logic.

## Interface
- `H_MAX`, 640: visible width in pixels
- `V_MAX`, 480: visible height in pixels
- `PAD_L_X`, 32: left paddle left edge x
- `PAD_R_X`, 600: right paddle left edge x (ball-facing face)
- `PAD_W`, 8: paddle width
- `PAD_H`, 72: paddle height
- `BALL_V`, 2: initial speed, pixels/frame, 1..7
- `MAX_V`, 6: speed ceiling when speed-up is compiled in, BALL_V..7
- `MISS_FRAMES`, 60: frames held in MISS before re-centering, 1..255
- `clk` input 1: system/pixel clock
- `reset` input 1: asynchronous, active-high
- `pixel_x` input 10: current scan x
- `pixel_y` input 10: current scan y
- `video_on` input 1: visible region flag
- `frame_tick` input 1: one-cycle pulse at start of vertical blank
- `serve` input 1: one-cycle pulse; starts play from IDLE
- `serve_dir` input 1: 0 = serve leftward, 1 = rightward
- `pad_l_y` input 10: left paddle top y
- `pad_r_y` input 10: right paddle top y
- `rom_addr` output 5: row address to ball bitmap ROM
- `rom_data` input 32 [0:31]: ROM row, bit 0 = leftmost pixel, combinational return
- `ball_on` output 1: registered ball-pixel flag
- `ball_x` output 10: ball top-left x
- `ball_y` output 10: ball top-left y
- `hit` output 1: one-cycle pulse on paddle bounce
- `miss_left` output 1: one-cycle pulse, ball passed left edge
- `miss_right` output 1: one-cycle pulse, ball passed right edge

## Operation
- Ball is 32x32. Centre position is `CX=(H_MAX-32)/2` (304) and `CY=(V_MAX-32)/2` (224).
- States:
  - IDLE: ball held at centre. `serve` → PLAY; load `dx=serve_dir`, `dy=down`, `speed=BALL_V`.
  - PLAY: motion is updated on each `frame_tick`.
  - MISS: ball frozen. A frame counter runs to `MISS_FRAMES` ticks, then → IDLE with the ball re-centred.
- `serve` is ignored outside IDLE.
- PLAY vertical update, per tick:
  - Moving up and `ball_y < speed`: `ball_y=0`, `dy=down`.
  - Moving down and `ball_y+32+speed > V_MAX`: `ball_y=V_MAX-32`, `dy=up`.
  - Otherwise `ball_y ± speed`.
- PLAY horizontal update, per tick. Priority order: paddle hit, then miss, then move.
  - Left hit: moving left, `ball_x >= PAD_L_X+PAD_W`, `ball_x < PAD_L_X+PAD_W+speed`, and vertical overlap `ball_y+32 > pad_l_y` and `ball_y < pad_l_y+PAD_H`. Response: `ball_x=PAD_L_X+PAD_W`, `dx=right`, pulse `hit`.
  - Right hit: moving right, `ball_x+32 <= PAD_R_X`, `ball_x+32+speed > PAD_R_X`, and overlap with `pad_r_y`. Response: `ball_x=PAD_R_X-32`, `dx=left`, pulse `hit`.
  - Left miss: moving left, `ball_x < speed`. Response: pulse `miss_left`, → MISS.
  - Right miss: moving right, `ball_x+32+speed > H_MAX`. Response: pulse `miss_right`, → MISS.
- Vertical and horizontal updates apply in the same tick.
- All position arithmetic uses 11-bit unsigned intermediates, so there is no wrap.
- Pixel path, computed combinationally:
  - `ox=pixel_x-ball_x`, `oy=pixel_y-ball_y`, each 11 bits.
  - `in_box = video_on & ox<32 & oy<32`.
  - `rom_addr = in_box ? oy[4:0] : 0`.
  - `ball_on` is registered as `in_box & rom_data[ox[4:0]]`.

## Timing
- `ball_on` is valid 1 clk after the corresponding `pixel_x`/`pixel_y`/`video_on`.
- Position, direction and state change only on the clk edge where `frame_tick=1`, with one exception: the `serve` transition happens on any edge.
- `hit`, `miss_left` and `miss_right` assert for exactly one clk, on the `frame_tick` edge that detects the event.
- `serve` and `frame_tick` in the same cycle while in IDLE: enter PLAY, no motion that tick.
- `ball_x`/`ball_y` update at `frame_tick`, which is in blanking, so no tearing within a frame.
- Reset values:
  - State IDLE; `ball_x=304`, `ball_y=224`.
  - `dx=right`, `dy=down`, `speed=BALL_V`, miss counter 0.
  - `ball_on=0`, `hit=0`, `miss_left=0`, `miss_right=0`.
- Reset asserted mid-play returns immediately to these values.

## Configuration
- `BALL_SPEEDUP_EN` defined: each `hit` increments `speed` by 1, saturating at `MAX_V`. `speed` returns to `BALL_V` on serve.
- `BALL_SPEEDUP_EN` undefined: `speed` is constant `BALL_V`, and `MAX_V` is unused.

## Structure
- Shared package `pong_pkg`: `BALL_SIZE=32`, screen dimension constants, and the state enum typedef `ball_state_t` (IDLE, PLAY, MISS).
- Sub-module `ball_pixel_pipe`: offset compute, `rom_addr` generation and the `ball_on` register.
- Motion FSM and position registers live in the top module.
- The bitmap ROM is instantiated outside this block.

## Test plan
- Reset, then scan pixel (304,224) with a ROM row of all ones → `ball_on=1` one clk later. Pixel (303,224) → `ball_on=0`.
- Serve with `serve_dir=1`, speed 2, 10 frame ticks → `ball_x=324`, `ball_y=244`.
- Ball at y=1 moving up, speed 2 → next tick `ball_y=0`, `dy=down`. Following tick `ball_y=2`.
- Ball at x=42 moving left, `pad_l_y` overlapping → `ball_x=40`, `dx=right`, `hit` pulse. With `BALL_SPEEDUP_EN`, `speed` becomes 3.
- Same approach with the paddle out of range, run to x<2 → `miss_left` pulse, state MISS. After 60 ticks, back to IDLE at (304,224).
- `serve` during PLAY → ignored. Reset asserted mid-PLAY → all reset values next cycle.
